// File: rtl/riscv_core_div_pkg.sv
// ============================================================================
// Module      : riscv_core_div_pkg
// Description : Shared op encoding, FSM states and constants for the divider
//               result-side logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_core_div_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] C_OP_DIV  = 2'b00;
   localparam logic [1:0] C_OP_DIVU = 2'b01;
   localparam logic [1:0] C_OP_REM  = 2'b10;
   localparam logic [1:0] C_OP_REMU = 2'b11;

   localparam logic [XLEN-1:0] C_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] C_ALL_ONES = {XLEN{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } div_state_e;

   // Bit 0 of the op selects unsigned, bit 1 selects remainder.
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_rem(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_core_div_special.sv
// ============================================================================
// Module      : riscv_core_div_special
// Description : Detects divide-by-zero and signed overflow and forms the
//               architecturally defined result for those cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_core_div_special
   import riscv_core_div_pkg::*;
(
   input  logic [XLEN-1:0] i_srcA,
   input  logic [XLEN-1:0] i_srcB,
   input  logic [1:0]      i_control,
   output logic            o_special,
   output logic [XLEN-1:0] o_result
);

   logic w_is_rem;
   logic w_div_zero;
   logic w_overflow;

   assign w_is_rem   = op_is_rem(i_control);
   assign w_div_zero = (i_srcB == '0);
   assign w_overflow = op_is_signed(i_control) && (i_srcA == C_INT_MIN) &&
                       (i_srcB == C_ALL_ONES);

   assign o_special = w_div_zero | w_overflow;

   // Zero divisor takes priority; overflow quotient is the dividend itself.
   always_comb begin
      o_result = '0;
      if (w_div_zero) begin
         o_result = w_is_rem ? i_srcA : C_ALL_ONES;
      end else if (w_overflow) begin
         o_result = w_is_rem ? '0 : i_srcA;
      end
   end

endmodule

`default_nettype wire

// File: rtl/riscv_core_div_out.sv
// ============================================================================
// Module      : riscv_core_div_out
// Description : Captures divide context, applies sign restoration or special
//               results, and holds the result under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_core_div_out
   import riscv_core_div_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_div_out_start,
   input  logic [XLEN-1:0] i_div_out_srcA,
   input  logic [XLEN-1:0] i_div_out_srcB,
   input  logic [1:0]      i_div_out_control,
   input  logic            i_div_out_core_done,
   input  logic [XLEN-1:0] i_div_out_quotient,
   input  logic [XLEN-1:0] i_div_out_remainder,
   input  logic            i_div_out_ready,
   output logic            o_div_out_valid,
   output logic [XLEN-1:0] o_div_out_result,
   output logic            o_div_out_busy,
   output logic            o_div_out_abort
);

   div_state_e      r_state;
   logic            r_is_rem;
   logic            r_neg;
   logic            r_valid;
   logic [XLEN-1:0] r_result;
   logic            r_busy;
   logic            r_abort;

   logic            w_special;
   logic [XLEN-1:0] w_special_result;
   logic            w_neg;
   logic [XLEN-1:0] w_sel;
   logic [XLEN-1:0] w_fixed;

   riscv_core_div_special u_special (
      .i_srcA    (i_div_out_srcA),
      .i_srcB    (i_div_out_srcB),
      .i_control (i_div_out_control),
      .o_special (w_special),
      .o_result  (w_special_result)
   );

   // Quotient is negative when operand signs differ; remainder follows dividend.
   assign w_neg = op_is_signed(i_div_out_control) &
                  (op_is_rem(i_div_out_control) ?
                      i_div_out_srcA[XLEN-1] :
                      (i_div_out_srcA[XLEN-1] ^ i_div_out_srcB[XLEN-1]));

   assign w_sel   = r_is_rem ? i_div_out_remainder : i_div_out_quotient;
   assign w_fixed = r_neg ? (~w_sel + {{(XLEN-1){1'b0}}, 1'b1}) : w_sel;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_is_rem <= 1'b0;
         r_neg    <= 1'b0;
         r_valid  <= 1'b0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_abort  <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_div_out_start) begin
                  r_is_rem <= op_is_rem(i_div_out_control);
                  r_neg    <= w_neg;
                  r_busy   <= 1'b1;
                  if (w_special) begin
                     r_result <= w_special_result;
                     r_valid  <= 1'b1;
                     r_abort  <= 1'b1;
                     r_state  <= ST_HOLD;
                  end else begin
                     r_state  <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (i_div_out_core_done) begin
                  r_result <= w_fixed;
                  r_valid  <= 1'b1;
                  r_state  <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (i_div_out_ready) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_div_out_valid  = r_valid;
   assign o_div_out_result = r_result;
   assign o_div_out_busy   = r_busy;
   assign o_div_out_abort  = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_riscv_core_div_out.sv
// ============================================================================
// Module      : tb_riscv_core_div_out
// Description : Scoreboard bench for the divider result stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_core_div_out;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [1:0]  ctl;
   logic        core_done;
   logic [31:0] quot;
   logic [31:0] rem;
   logic        ready;
   logic        valid;
   logic [31:0] result;
   logic        busy;
   logic        abort;

   int n_tests;
   int n_fail;
   logic [31:0] sb_q[$];

   riscv_core_div_out dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_div_out_start     (start),
      .i_div_out_srcA      (srcA),
      .i_div_out_srcB      (srcB),
      .i_div_out_control   (ctl),
      .i_div_out_core_done (core_done),
      .i_div_out_quotient  (quot),
      .i_div_out_remainder (rem),
      .i_div_out_ready     (ready),
      .o_div_out_valid     (valid),
      .o_div_out_result    (result),
      .o_div_out_busy      (busy),
      .o_div_out_abort     (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference RISC-V semantics, independent of the DUT's structure.
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
      case (op)
         2'b00:   return $signed(a) / $signed(b);
         2'b10:   return $signed(a) % $signed(b);
         2'b01:   return a / b;
         default: return a % b;
      endcase
   endfunction

   // Transfer point: pop the oldest expected result on every handshake.
   always @(negedge clk) begin
      if (!rst && valid && ready) begin
         if (sb_q.size() == 0) check("sb_unexpected", result, 32'hDEAD_BEEF);
         else check("sb_result", result, sb_q.pop_front());
      end
   end

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; ctl = op; srcA = a; srcB = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic handshake();
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      check("valid_after_xfer", {31'b0, valid}, 32'd0);
      check("busy_after_xfer", {31'b0, busy}, 32'd0);
   endtask

   task automatic run_normal(input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int hold);
      logic [31:0] ma, mb, exp;
      ma  = (!op[0] && a[31]) ? -a : a;
      mb  = (!op[0] && b[31]) ? -b : b;
      exp = ref_result(op, a, b);
      sb_q.push_back(exp);
      start_op(op, a, b);
      check("busy_T1", {31'b0, busy}, 32'd1);
      check("valid_wait", {31'b0, valid}, 32'd0);
      check("abort_normal", {31'b0, abort}, 32'd0);
      @(posedge clk); #1;
      core_done = 1'b1; quot = ma / mb; rem = ma % mb;
      @(posedge clk); #1;
      core_done = 1'b0; quot = 32'h1234_5678; rem = 32'h8765_4321;
      check("valid_D1", {31'b0, valid}, 32'd1);
      check("result_D1", result, exp);
      for (int i = 0; i < hold; i++) begin
         // A divide-by-zero start here would pulse abort if it were accepted.
         if (i == 0) begin start = 1'b1; ctl = 2'b00; srcA = 32'd9; srcB = 32'd0; end
         @(posedge clk); #1;
         start = 1'b0;
         check("hold_valid", {31'b0, valid}, 32'd1);
         check("hold_result", result, exp);
         check("hold_abort", {31'b0, abort}, 32'd0);
      end
      handshake();
   endtask

   task automatic run_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      exp = ref_result(op, a, b);
      sb_q.push_back(exp);
      start_op(op, a, b);
      check("sp_abort_T1", {31'b0, abort}, 32'd1);
      check("sp_valid_T1", {31'b0, valid}, 32'd1);
      check("sp_busy_T1", {31'b0, busy}, 32'd1);
      check("sp_result_T1", result, exp);
      core_done = 1'b1; quot = 32'h0BAD_0BAD; rem = 32'h0BAD_0BAD;
      @(posedge clk); #1;
      core_done = 1'b0;
      check("sp_abort_T2", {31'b0, abort}, 32'd0);
      check("sp_result_T2", result, exp);
      check("sp_valid_T2", {31'b0, valid}, 32'd1);
      handshake();
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1'b1; start = 1'b0; srcA = '0; srcB = '0; ctl = '0;
      core_done = 1'b0; quot = '0; rem = '0; ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_abort", {31'b0, abort}, 32'd0);
      check("rst_result", result, 32'd0);

      core_done = 1'b1; quot = 32'd77;
      @(posedge clk); #1;
      core_done = 1'b0;
      check("idle_done_ignored", {31'b0, valid}, 32'd0);

      run_normal(2'b00, 32'hFFFF_FFF9, 32'h2, 0);
      run_normal(2'b10, 32'hFFFF_FFF9, 32'h2, 0);
      run_normal(2'b01, 32'hFFFF_FFF9, 32'h2, 0);
      run_normal(2'b11, 32'hFFFF_FFF9, 32'h2, 0);
      run_normal(2'b00, 32'h7, 32'hFFFF_FFFE, 0);
      run_normal(2'b10, 32'h7, 32'hFFFF_FFFE, 0);
      run_normal(2'b10, 32'hFFFF_FFF8, 32'h2, 0);
      run_normal(2'b00, 32'h8000_0000, 32'h2, 0);

      run_special(2'b00, 32'h5, 32'h0);
      run_special(2'b10, 32'h5, 32'h0);
      run_special(2'b01, 32'hFFFF_FFF9, 32'h0);
      run_special(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      run_special(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

      run_normal(2'b00, 32'hFFFF_FF9C, 32'd10, 3);
      run_normal(2'b11, 32'd100, 32'd7, 0);

      for (int i = 0; i < 16; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom;
         if (i[0]) b = b >> (b[4:0]);
         if (b == 32'h0) b = 32'd3;
         if (b == 32'hFFFF_FFFF) b = 32'd5;
         run_normal(2'($urandom_range(0, 3)), a, b, i % 2);
      end

      // Reset while waiting on the divider discards the operation.
      start_op(2'b00, 32'd100, 32'd3);
      check("rw_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rw_valid", {31'b0, valid}, 32'd0);
      check("rw_busy_clr", {31'b0, busy}, 32'd0);
      check("rw_result", result, 32'd0);
      core_done = 1'b1; quot = 32'd33; rem = 32'd1;
      @(posedge clk); #1;
      core_done = 1'b0;
      @(posedge clk); #1;
      check("rw_done_ignored", {31'b0, valid}, 32'd0);
      check("rw_result_hold", result, 32'd0);

      run_normal(2'b10, 32'hFFFF_FF9B, 32'd10, 0);

      check("sb_drain", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/riscv_core_div_out.md
# riscv_core_div_out

Result-side companion of the divider operand conditioner. Captures the operation context at divide start, then waits for the iterative unsigned divider to finish. It then restores the sign of the quotient or remainder and resolves the RISC-V divide-by-zero and signed-overflow cases. The registered result is presented to the EX/MEM stage under a valid/ready handshake.

## Interface
- XLEN, 32, datapath width.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_div_out_start  in  1  new divide issued this cycle; accepted only in IDLE.
- i_div_out_srcA  in  XLEN  original (unconditioned) dividend; sampled on accepted start.
- i_div_out_srcB  in  XLEN  original divisor; sampled on accepted start.
- i_div_out_control  in  2  op: DIV=00, DIVU=01, REM=10, REMU=11; sampled on accepted start.
- i_div_out_core_done  in  1  iterative divider result valid; one-cycle pulse.
- i_div_out_quotient  in  XLEN  unsigned quotient magnitude; valid with core_done.
- i_div_out_remainder  in  XLEN  unsigned remainder magnitude; valid with core_done.
- i_div_out_ready  in  1  consumer accepts result.
- o_div_out_valid  out  1  result held and valid; reset 0.
- o_div_out_result  out  XLEN  signed-corrected result; reset 0.
- o_div_out_busy  out  1  high in WAIT or HOLD (pipeline stall); reset 0.
- o_div_out_abort  out  1  one-cycle pulse cancelling the iterative divider on special case; reset 0.

## Operation
- FSM states: IDLE, WAIT, HOLD; reset state IDLE.
- IDLE, start=1: register control, neg_q = srcA[XLEN-1]^srcB[XLEN-1] (DIV only), neg_r = srcA[XLEN-1] (REM only), srcA copy.
  - Divide-by-zero (srcB==0), any op: result = all-ones for DIV/DIVU, srcA for REM/REMU. Pulse abort, go HOLD.
  - Signed overflow (DIV/REM, srcA==1<<(XLEN-1), srcB==all-ones): DIV result = srcA, REM result = 0. Pulse abort, go HOLD.
  - Otherwise go WAIT.
- WAIT, core_done=1: sel = quotient (DIV/DIVU) or remainder (REM/REMU).
  - result = neg ? (~sel + 1) : sel, mod 2^XLEN; neg = neg_q for DIV, neg_r for REM, 0 for unsigned.
  - Go HOLD.
- HOLD: valid=1, result stable. When ready=1, go IDLE with valid cleared.
- Ignored inputs:
  - start outside IDLE (busy already high).
  - core_done outside WAIT.
  - ready outside HOLD.
- Zero remainder with neg_r set yields 0 (two's complement of 0).
- Reset in any state: IDLE next cycle, all outputs 0, captured context discarded. A core_done arriving afterward is ignored.

## Timing
- Start accepted at cycle T:
  - busy high from T+1.
  - Special case: abort high during T+1 only; valid high from T+1.
- Normal path: core_done at cycle D (D≥T+1) → valid and result at D+1.
- Handshake: transfer in any cycle with valid&ready. Valid low the next cycle; next start accepted no earlier than that cycle.
- Result, valid and busy are registered outputs. Abort is registered.

## Structure
- Shared package riscv_core_div_pkg:
  - op localparams DIV/DIVU/REM/REMU, identical encoding to the operand conditioner.
  - FSM state enum.
  - XLEN-parameterised constants INT_MIN and ALL_ONES.
- One natural sub-module: riscv_core_div_special. It is combinational and detects divide-by-zero/overflow and produces the special-case result from srcA, srcB and control.
- Sign fixup stays inline in riscv_core_div_out.

## Test plan
- DIV -7/2: start srcA=0xFFFFFFF9, srcB=0x2; core_done 2 cycles later with quotient=3, remainder=1 → result 0xFFFFFFFD valid 1 cycle after done; REM same operands → 0xFFFFFFFF.
- DIVU/REMU 0xFFFFFFF9/2: quotient=0x7FFFFFFC, remainder=1 → results 0x7FFFFFFC / 0x00000001, no negation.
- Divide-by-zero: DIV 5/0 → abort pulse at T+1, result 0xFFFFFFFF at T+1; REM 5/0 → 0x00000005; a later core_done pulse is ignored.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0x00000000, abort pulsed, no wait for core_done.
- Backpressure: hold ready=0 for 3 cycles in HOLD → result/valid stable; start asserted during HOLD is ignored; ready=1 → valid low next cycle, then new start accepted.
- Reset mid-operation: assert i_rst in WAIT → next cycle valid=0, busy=0, result=0; core_done afterward produces no valid.
